power_dispatch: RTL and testbench

- Downstream consumer of the reservoir's per-cycle `electric` output.
- Accumulates generated energy into a bounded storage bank and serves load requests over a valid/ready handshake.
- Tracks consecutive under-served requests and enters a load-shedding state until storage recovers.
- Sits between the reservoir model and the consumer/grid side of the design.

---
 rtl/power_dispatch_pkg.sv | 22 ++
 rtl/power_dispatch_energy_store.sv | 50 +++++
 rtl/power_dispatch.sv | 143 ++++++++++++++
 tb/tb_power_dispatch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power_dispatch_pkg.sv
// Shared types and default constants for the power dispatch block.
// Optional build macro: DISPATCH_STATS_EN (served/spilled energy counters).
package power_dispatch_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned ENERGY_W  = 8;
    localparam int unsigned DEFICIT_W = 4;
    localparam int unsigned STATS_W   = 16;

    localparam int unsigned DEF_CAP_W      = 12;
    localparam int unsigned DEF_CAPACITY   = 4000;
    localparam int unsigned DEF_LOW_MARK   = 256;
    localparam int unsigned DEF_HIGH_MARK  = 1024;
    localparam int unsigned DEF_SHED_LIMIT = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SHED  = 2'd2
    } state_t;

endpackage

// File: rtl/power_dispatch_energy_store.sv
// Storage bank datapath: adds generation, removes granted energy, clamps and reports spill.
module energy_store
    import power_dispatch_pkg::*;
#(
    parameter int unsigned CAP_W    = DEF_CAP_W,
    parameter int unsigned CAPACITY = DEF_CAPACITY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gen_valid,
    input  logic [ENERGY_W-1:0] gen_in,
    input  logic                take_req,
    input  logic [ENERGY_W-1:0] req_amt,
    output logic [ENERGY_W-1:0] take_c,
    output logic [CAP_W-1:0]    stored,
    output logic [ENERGY_W-1:0] spill
);

    localparam int unsigned SUM_W = CAP_W + 1;

    logic [SUM_W-1:0] avail_c;
    logic [SUM_W-1:0] rem_c;
    logic [SUM_W-1:0] excess_c;

    // Generation lands in avail before the grant is carved out of it.
    always_comb begin
        avail_c = SUM_W'(stored) + (gen_valid ? SUM_W'(gen_in) : SUM_W'(0));
        take_c  = '0;
        if (take_req) begin
            take_c = (SUM_W'(req_amt) < avail_c) ? req_amt : ENERGY_W'(avail_c);
        end
        rem_c    = avail_c - SUM_W'(take_c);
        excess_c = rem_c - SUM_W'(CAPACITY);
    end

    // Stored register clamps at CAPACITY; overflow reported for one cycle, saturated to 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stored <= '0;
            spill  <= '0;
        end else if (rem_c > SUM_W'(CAPACITY)) begin
            stored <= CAP_W'(CAPACITY);
            spill  <= (excess_c > SUM_W'(255)) ? 8'hFF : ENERGY_W'(excess_c);
        end else begin
            stored <= CAP_W'(rem_c);
            spill  <= '0;
        end
    end

endmodule

// File: rtl/power_dispatch.sv
// Energy dispatch: stores reservoir output and serves load requests, shedding load
// after repeated under-served grants. Optional build macro: DISPATCH_STATS_EN.
module power_dispatch
    import power_dispatch_pkg::*;
#(
    parameter int unsigned CAP_W      = DEF_CAP_W,
    parameter int unsigned CAPACITY   = DEF_CAPACITY,
    parameter int unsigned LOW_MARK   = DEF_LOW_MARK,
    parameter int unsigned HIGH_MARK  = DEF_HIGH_MARK,
    parameter int unsigned SHED_LIMIT = DEF_SHED_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gen_valid,
    input  logic [ENERGY_W-1:0] gen_in,
    input  logic                load_req_valid,
    input  logic [ENERGY_W-1:0] load_req_amt,
    output logic                load_req_ready,
    output logic                grant_valid,
    input  logic                grant_ready,
    output logic [ENERGY_W-1:0] grant_amt,
    output logic                grant_full,
    output logic [CAP_W-1:0]    stored,
    output logic [ENERGY_W-1:0] spill,
    output logic                low_flag,
    output logic                shed,
    output logic [STATE_W-1:0]  state
`ifdef DISPATCH_STATS_EN
    ,
    output logic [STATS_W-1:0]  served_total,
    output logic [STATS_W-1:0]  spilled_total
`endif
);

    state_t               state_q;
    logic [DEFICIT_W-1:0] deficit_q;
    logic [DEFICIT_W-1:0] deficit_inc_c;
    logic [ENERGY_W-1:0]  take_c;
    logic                 accept_c;
    logic                 handshake_c;

    assign accept_c      = load_req_valid && load_req_ready;
    assign handshake_c   = grant_valid && grant_ready;
    assign deficit_inc_c = deficit_q + DEFICIT_W'(1);
    assign low_flag      = (stored < CAP_W'(LOW_MARK));
    assign state         = state_q;

    energy_store #(
        .CAP_W    (CAP_W),
        .CAPACITY (CAPACITY)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .gen_valid (gen_valid),
        .gen_in    (gen_in),
        .take_req  (accept_c),
        .req_amt   (load_req_amt),
        .take_c    (take_c),
        .stored    (stored),
        .spill     (spill)
    );

    // Dispatch FSM with registered handshake outputs and the deficit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            load_req_ready <= 1'b0;
            grant_valid    <= 1'b0;
            grant_amt      <= '0;
            grant_full     <= 1'b0;
            shed           <= 1'b0;
            deficit_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load_req_ready <= 1'b1;
                    if (accept_c) begin
                        grant_amt      <= take_c;
                        grant_full     <= (take_c == load_req_amt);
                        grant_valid    <= 1'b1;
                        load_req_ready <= 1'b0;
                        state_q        <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (handshake_c) begin
                        grant_valid <= 1'b0;
                        if (grant_full) begin
                            deficit_q      <= '0;
                            load_req_ready <= 1'b1;
                            state_q        <= ST_IDLE;
                        end else if (deficit_inc_c == DEFICIT_W'(SHED_LIMIT)) begin
                            deficit_q <= deficit_inc_c;
                            shed      <= 1'b1;
                            state_q   <= ST_SHED;
                        end else begin
                            deficit_q      <= deficit_inc_c;
                            load_req_ready <= 1'b1;
                            state_q        <= ST_IDLE;
                        end
                    end
                end
                ST_SHED: begin
                    if (stored >= CAP_W'(HIGH_MARK)) begin
                        deficit_q      <= '0;
                        shed           <= 1'b0;
                        load_req_ready <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    shed           <= 1'b0;
                    load_req_ready <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    localparam int unsigned ACC_W = STATS_W + 1;

    logic [ACC_W-1:0] served_sum_c;
    logic [ACC_W-1:0] spilled_sum_c;

    assign served_sum_c  = ACC_W'(served_total) + ACC_W'(grant_amt);
    assign spilled_sum_c = ACC_W'(spilled_total) + ACC_W'(spill);

    // Saturating totals of delivered and overflowed energy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_total  <= '0;
            spilled_total <= '0;
        end else begin
            if (handshake_c) begin
                served_total <= served_sum_c[STATS_W] ? '1 : served_sum_c[STATS_W-1:0];
            end
            spilled_total <= spilled_sum_c[STATS_W] ? '1 : spilled_sum_c[STATS_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_power_dispatch.sv
// Directed self-checking bench for power_dispatch (default configuration).
module tb_power_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_valid;
    logic [7:0]  gen_in;
    logic        load_req_valid;
    logic [7:0]  load_req_amt;
    logic        load_req_ready;
    logic        grant_valid;
    logic        grant_ready;
    logic [7:0]  grant_amt;
    logic        grant_full;
    logic [11:0] stored;
    logic [7:0]  spill;
    logic        low_flag;
    logic        shed;
    logic [1:0]  state;
`ifdef DISPATCH_STATS_EN
    logic [15:0] served_total;
    logic [15:0] spilled_total;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    power_dispatch dut (
        .clk            (clk),
        .rst            (rst),
        .gen_valid      (gen_valid),
        .gen_in         (gen_in),
        .load_req_valid (load_req_valid),
        .load_req_amt   (load_req_amt),
        .load_req_ready (load_req_ready),
        .grant_valid    (grant_valid),
        .grant_ready    (grant_ready),
        .grant_amt      (grant_amt),
        .grant_full     (grant_full),
        .stored         (stored),
        .spill          (spill),
        .low_flag       (low_flag),
        .shed           (shed),
        .state          (state)
`ifdef DISPATCH_STATS_EN
        ,
        .served_total   (served_total),
        .spilled_total  (spilled_total)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        gen_valid      = 1'b0;
        gen_in         = 8'd0;
        load_req_valid = 1'b0;
        load_req_amt   = 8'd0;
        grant_ready    = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #1;
        vectors++; if (stored !== 12'd0) begin miscompares++; $display("FAIL reset_stored: got %0d want 0", stored); end
        vectors++; if (spill !== 8'd0) begin miscompares++; $display("FAIL reset_spill: got %0d want 0", spill); end
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
        vectors++; if (grant_amt !== 8'd0) begin miscompares++; $display("FAIL reset_grant_amt: got %0d want 0", grant_amt); end
        vectors++; if (grant_full !== 1'b0) begin miscompares++; $display("FAIL reset_grant_full: got %b want 0", grant_full); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++; if (shed !== 1'b0) begin miscompares++; $display("FAIL reset_shed: got %b want 0", shed); end
        vectors++; if (load_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", load_req_ready); end
        vectors++; if (low_flag !== 1'b1) begin miscompares++; $display("FAIL reset_low_flag: got %b want 1", low_flag); end
        @(negedge clk);
        rst = 1'b0;
        step();
        vectors++; if (load_req_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", load_req_ready); end
        vectors++; if (low_flag !== 1'b1) begin miscompares++; $display("FAIL release_low_flag: got %b want 1", low_flag); end
    endtask

    task automatic test_charging();
        gen_valid = 1'b1;
        gen_in    = 8'd200;
        step();
        vectors++; if (stored !== 12'd200) begin miscompares++; $display("FAIL charge_first: got %0d want 200", stored); end
        vectors++; if (low_flag !== 1'b1) begin miscompares++; $display("FAIL charge_low_200: got %b want 1", low_flag); end
        for (int i = 0; i < 9; i++) step();
        vectors++; if (stored !== 12'd2000) begin miscompares++; $display("FAIL charge_stored: got %0d want 2000", stored); end
        vectors++; if (spill !== 8'd0) begin miscompares++; $display("FAIL charge_spill: got %0d want 0", spill); end
        vectors++; if (low_flag !== 1'b0) begin miscompares++; $display("FAIL charge_low: got %b want 0", low_flag); end
        gen_valid = 1'b0;
        gen_in    = 8'd0;
    endtask

    task automatic test_full_grant_stall();
        load_req_valid = 1'b1;
        load_req_amt   = 8'd150;
        step();
        vectors++; if (grant_valid !== 1'b1) begin miscompares++; $display("FAIL grant_valid: got %b want 1", grant_valid); end
        vectors++; if (grant_amt !== 8'd150) begin miscompares++; $display("FAIL grant_amt: got %0d want 150", grant_amt); end
        vectors++; if (grant_full !== 1'b1) begin miscompares++; $display("FAIL grant_full: got %b want 1", grant_full); end
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL grant_state: got %0d want 1", state); end
        vectors++; if (stored !== 12'd1850) begin miscompares++; $display("FAIL grant_stored: got %0d want 1850", stored); end
        // request held high while not ready must not be taken again
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (grant_valid !== 1'b1 || grant_amt !== 8'd150 || grant_full !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got v=%b amt=%0d full=%b want v=1 amt=150 full=1", i, grant_valid, grant_amt, grant_full);
            end
            vectors++; if (load_req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d]: got %b want 0", i, load_req_ready); end
            vectors++; if (stored !== 12'd1850) begin miscompares++; $display("FAIL stall_stored[%0d]: got %0d want 1850", i, stored); end
        end
        load_req_valid = 1'b0;
        grant_ready    = 1'b1;
        step();
        grant_ready = 1'b0;
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL hs_grant_valid: got %b want 0", grant_valid); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL hs_state: got %0d want 0", state); end
        vectors++; if (load_req_ready !== 1'b1) begin miscompares++; $display("FAIL hs_ready: got %b want 1", load_req_ready); end
    endtask

    task automatic test_overflow();
        gen_valid = 1'b1;
        gen_in    = 8'd205;
        for (int i = 0; i < 10; i++) step();
        vectors++; if (stored !== 12'd3900) begin miscompares++; $display("FAIL ovf_pre: got %0d want 3900", stored); end
        gen_in = 8'd200;
        step();
        vectors++; if (stored !== 12'd4000) begin miscompares++; $display("FAIL ovf_stored: got %0d want 4000", stored); end
        vectors++; if (spill !== 8'd100) begin miscompares++; $display("FAIL ovf_spill: got %0d want 100", spill); end
        gen_in = 8'd0;
        step();
        vectors++; if (spill !== 8'd0) begin miscompares++; $display("FAIL ovf_spill_clear: got %0d want 0", spill); end
        vectors++; if (stored !== 12'd4000) begin miscompares++; $display("FAIL ovf_hold: got %0d want 4000", stored); end
    endtask

    task automatic test_simultaneous();
        // 4000 + 100 generated, 200 taken: 3900 left, nothing spilled
        gen_valid      = 1'b1;
        gen_in         = 8'd100;
        load_req_valid = 1'b1;
        load_req_amt   = 8'd200;
        step();
        vectors++; if (grant_amt !== 8'd200 || grant_full !== 1'b1) begin
            miscompares++; $display("FAIL simul_grant: got amt=%0d full=%b want amt=200 full=1", grant_amt, grant_full);
        end
        vectors++; if (stored !== 12'd3900) begin miscompares++; $display("FAIL simul_stored: got %0d want 3900", stored); end
        vectors++; if (spill !== 8'd0) begin miscompares++; $display("FAIL simul_spill: got %0d want 0", spill); end
        drive_idle();
        grant_ready = 1'b1;
        step();
        grant_ready = 1'b0;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL simul_state: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_grant();
        load_req_valid = 1'b1;
        load_req_amt   = 8'd10;
        step();
        load_req_valid = 1'b0;
        vectors++; if (grant_valid !== 1'b1 || stored !== 12'd3890) begin
            miscompares++; $display("FAIL mid_pre: got v=%b stored=%0d want v=1 stored=3890", grant_valid, stored);
        end
        rst = 1'b1;
        #1;
        vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL mid_grant_valid: got %b want 0", grant_valid); end
        vectors++; if (stored !== 12'd0) begin miscompares++; $display("FAIL mid_stored: got %0d want 0", stored); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL mid_state: got %0d want 0", state); end
        @(negedge clk);
        rst = 1'b0;
        step();
        vectors++; if (load_req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %b want 1", load_req_ready); end
    endtask

    task automatic test_deficit_shed();
        logic [1:0] exp_state;
        // one partial grant, then a zero-amount full grant that clears the count
        load_req_valid = 1'b1;
        load_req_amt   = 8'd50;
        step();
        load_req_valid = 1'b0;
        vectors++; if (grant_amt !== 8'd0 || grant_full !== 1'b0) begin
            miscompares++; $display("FAIL pre_partial: got amt=%0d full=%b want amt=0 full=0", grant_amt, grant_full);
        end
        grant_ready = 1'b1; step(); grant_ready = 1'b0;
        load_req_valid = 1'b1;
        load_req_amt   = 8'd0;
        step();
        load_req_valid = 1'b0;
        vectors++; if (grant_valid !== 1'b1 || grant_amt !== 8'd0 || grant_full !== 1'b1) begin
            miscompares++; $display("FAIL zero_req: got v=%b amt=%0d full=%b want v=1 amt=0 full=1", grant_valid, grant_amt, grant_full);
        end
        grant_ready = 1'b1; step(); grant_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load_req_valid = 1'b1;
            load_req_amt   = 8'd50;
            step();
            load_req_valid = 1'b0;
            vectors++; if (grant_valid !== 1'b1 || grant_amt !== 8'd0 || grant_full !== 1'b0) begin
                miscompares++; $display("FAIL deficit_grant[%0d]: got v=%b amt=%0d full=%b want v=1 amt=0 full=0", k, grant_valid, grant_amt, grant_full);
            end
            grant_ready = 1'b1; step(); grant_ready = 1'b0;
            exp_state = (k == 3) ? 2'd2 : 2'd0;
            vectors++; if (state !== exp_state) begin miscompares++; $display("FAIL deficit_state[%0d]: got %0d want %0d", k, state, exp_state); end
        end
        vectors++; if (shed !== 1'b1) begin miscompares++; $display("FAIL shed_flag: got %b want 1", shed); end
        vectors++; if (load_req_ready !== 1'b0) begin miscompares++; $display("FAIL shed_ready: got %b want 0", load_req_ready); end
        // recharge with a request held (ignored while shedding)
        gen_valid      = 1'b1;
        gen_in         = 8'd255;
        load_req_valid = 1'b1;
        load_req_amt   = 8'd50;
        for (int i = 0; i < 5; i++) step();
        vectors++; if (stored !== 12'd1275) begin miscompares++; $display("FAIL shed_charge: got %0d want 1275", stored); end
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL shed_still: got %0d want 2", state); end
        drive_idle();
        step();
        vectors++; if (state !== 2'd0 || shed !== 1'b0) begin miscompares++; $display("FAIL shed_exit: got state=%0d shed=%b want state=0 shed=0", state, shed); end
        vectors++; if (load_req_ready !== 1'b1) begin miscompares++; $display("FAIL shed_exit_ready: got %b want 1", load_req_ready); end
        vectors++; if (stored !== 12'd1275) begin miscompares++; $display("FAIL shed_exit_stored: got %0d want 1275", stored); end
    endtask

    initial begin
        test_reset();
        test_charging();
        test_full_grant_stall();
        test_overflow();
        test_simultaneous();
        test_reset_mid_grant();
        test_deficit_shed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
